// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared opcodes, instruction field positions and FSM encoding for the array sequencer
package seq_pkg;

    localparam int OP_W     = 4;
    localparam int OP_LSB   = 60;
    localparam int ADDR_LSB = 44;
    localparam int LEN_LSB  = 32;

    localparam logic [OP_W-1:0] OP_NOP     = 4'h0;
    localparam logic [OP_W-1:0] OP_LOAD_W  = 4'h1;
    localparam logic [OP_W-1:0] OP_LOAD_A  = 4'h2;
    localparam logic [OP_W-1:0] OP_COMPUTE = 4'h3;
    localparam logic [OP_W-1:0] OP_STORE   = 4'h4;
    localparam logic [OP_W-1:0] OP_HALT    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_HALTED
    } state_t;

    // Opcodes that become a command on the array datapath.
    function automatic logic is_array_op(input logic [OP_W-1:0] op);
        return (op >= OP_LOAD_W) && (op <= OP_STORE);
    endfunction

endpackage

// File: rtl/seq_timeout_timer.sv
// rtl/seq_timeout_timer.sv - saturating cycle counter that flags when a command has waited TIMEOUT cycles
module seq_timeout_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/array_sequencer.sv
// rtl/array_sequencer.sv - in-order, single-outstanding instruction sequencer for the systolic array
module array_sequencer
    import seq_pkg::*;
#(
    parameter int INSTR_W = 64,
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [3:0]         cmd_op,
    output logic [ADDR_W-1:0]  cmd_addr,
    output logic [LEN_W-1:0]   cmd_len,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    input  logic               unit_done,
    output logic               busy,
    output logic               halted,
    output logic               err_illegal,
    output logic               err_timeout,
    output logic [15:0]        retired_cnt
);

    state_t state;
    state_t state_next;

    logic [OP_W-1:0]   lat_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [LEN_W-1:0]  lat_len;

    logic pop;
    logic issue;
    logic accept;
    logic retire;
    logic timeout_hit;
    logic illegal_hit;
    logic timer_expire;
    logic unused_reserved;

    assign unused_reserved = ^instr_in[LEN_LSB-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        issue       = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;
        timeout_hit = 1'b0;
        illegal_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    pop        = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (lat_op == OP_NOP) begin
                    state_next = ST_IDLE;
                end else if (lat_op == OP_HALT) begin
                    state_next = ST_HALTED;
                end else if (is_array_op(lat_op)) begin
                    issue      = 1'b1;
                    state_next = ST_ISSUE;
                end else begin
                    illegal_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            // unit_done is deliberately not looked at here: a command cannot
            // complete in the cycle it is accepted.
            ST_ISSUE: begin
                if (cmd_ready) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (unit_done) begin
                    retire     = 1'b1;
                    state_next = ST_IDLE;
                end else if (timer_expire) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_op      <= '0;
            lat_addr    <= '0;
            lat_len     <= '0;
            cmd_op      <= '0;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            cmd_valid   <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (pop) begin
                lat_op   <= instr_in[OP_LSB +: OP_W];
                lat_addr <= instr_in[ADDR_LSB +: ADDR_W];
                lat_len  <= instr_in[LEN_LSB +: LEN_W];
            end
            if (issue) begin
                cmd_op    <= lat_op;
                cmd_addr  <= lat_addr;
                cmd_len   <= lat_len;
                cmd_valid <= 1'b1;
            end else if (accept) begin
                cmd_valid <= 1'b0;
            end
            if (illegal_hit) begin
                err_illegal <= 1'b1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
        end
    end

    seq_timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (state == ST_WAIT_DONE),
        .expire (timer_expire)
    );

    // Gated with rst so that every output reads 0 while reset is held.
    assign instr_ready = (state == ST_IDLE) && !rst;
    assign busy        = (state == ST_DECODE) || (state == ST_ISSUE) || (state == ST_WAIT_DONE);
    assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_array_sequencer.sv
// tb/tb_array_sequencer.sv - directed bench for array_sequencer with a command scoreboard
module tb_array_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] instr_in = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [11:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        unit_done = 1'b0;
    logic        busy;
    logic        halted;
    logic        err_illegal;
    logic        err_timeout;
    logic [15:0] retired_cnt;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] addr;
        logic [11:0] len;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   valid_cycles = 0;
    int   exp_retired = 0;
    int   vc_mark = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) valid_cycles++;
    end

    array_sequencer #(
        .INSTR_W (64),
        .ADDR_W  (16),
        .LEN_W   (12),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .unit_done   (unit_done),
        .busy        (busy),
        .halted      (halted),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .retired_cnt (retired_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [15:0] addr,
                                       input logic [11:0] len);
        return {op, addr, len, 32'hDEAD_BEEF};
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        instr_valid = 1'b0;
        cmd_ready = 1'b0;
        unit_done = 1'b0;
        repeat (cycles) tick();
        check("reset_outputs", {instr_ready, cmd_valid, cmd_op, cmd_addr, cmd_len, busy, halted,
                                err_illegal, err_timeout, retired_cnt}, 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", instr_ready, 1);
        exp_retired = 0;
        exp_q.delete();
    endtask

    task automatic push(input logic [3:0] op, input logic [15:0] addr, input logic [11:0] len);
        int n;
        cmd_t e;
        n = 0;
        instr_in = mk(op, addr, len);
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!instr_ready) check("pop_ready", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        if (op inside {[4'd1:4'd4]}) begin
            e = '{op, addr, len};
            exp_q.push_back(e);
        end
    endtask

    // done_delay >= 0: pulse unit_done after that many idle cycles;
    // -1: never pulse and expect the timeout; -2: leave the command outstanding.
    task automatic run_cmd(input int stall, input int done_delay, input bit early_done);
        int   n;
        cmd_t e;
        n = 0;
        cmd_ready = 1'b0;
        while (!cmd_valid && n < 20) begin
            tick();
            n++;
        end
        check("cmd_valid_seen", cmd_valid, 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{4'h0, 16'h0, 12'h0};
        check("cmd_op", cmd_op, e.op);
        check("cmd_addr", cmd_addr, e.addr);
        check("cmd_len", cmd_len, e.len);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_hold", {cmd_valid, cmd_op, cmd_addr, cmd_len}, {1'b1, e.op, e.addr, e.len});
        end
        cmd_ready = 1'b1;
        unit_done = early_done;
        tick();
        cmd_ready = 1'b0;
        unit_done = 1'b0;
        check("valid_dropped", cmd_valid, 0);
        if (early_done) check("early_done_ignored", {busy, retired_cnt}, {1'b1, 16'(exp_retired)});
        if (done_delay >= 0) begin
            repeat (done_delay) tick();
            unit_done = 1'b1;
            tick();
            unit_done = 1'b0;
            exp_retired++;
            check("retired_cnt", retired_cnt, 16'(exp_retired));
            check("busy_after_done", busy, 0);
        end else if (done_delay == -1) begin
            n = 0;
            while (!err_timeout && n < 40) begin
                tick();
                n++;
            end
            check("timeout_latency", n, TIMEOUT);
            check("idle_after_timeout", {busy, instr_ready}, 2'b01);
            check("retired_after_timeout", retired_cnt, 16'(exp_retired));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);

        // single LOAD_W, one valid cycle, done five cycles after the handshake
        vc_mark = valid_cycles;
        push(4'h1, 16'h0010, 12'd8);
        run_cmd(0, 4, 1'b0);
        check("single_valid_cycle", valid_cycles - vc_mark, 1);

        // in-order sequence with a stall on COMPUTE
        do_reset(2);
        vc_mark = valid_cycles;
        push(4'h1, 16'h1234, 12'hABC);
        run_cmd(0, 2, 1'b0);
        push(4'h2, 16'h0100, 12'd16);
        run_cmd(0, 0, 1'b0);
        push(4'h3, 16'h0200, 12'd32);
        run_cmd(3, 1, 1'b0);
        push(4'h4, 16'h0300, 12'd4);
        run_cmd(0, 6, 1'b0);
        check("seq_retired", retired_cnt, 16'd4);
        check("seq_valid_cycles", valid_cycles - vc_mark, 7);

        // NOP and illegal opcode issue nothing; the next LOAD_A still runs
        vc_mark = valid_cycles;
        push(4'h0, 16'hFFFF, 12'hFFF);
        tick();
        check("nop_idle", {cmd_valid, busy, instr_ready}, 3'b001);
        push(4'h7, 16'hAAAA, 12'h555);
        tick();
        check("illegal_flag", {err_illegal, cmd_valid, instr_ready}, 3'b101);
        check("no_issue_nop_illegal", valid_cycles - vc_mark, 0);
        push(4'h2, 16'h0BEE, 12'd3);
        run_cmd(0, 3, 1'b0);
        check("illegal_sticky", err_illegal, 1);

        // done in the same cycle as the handshake is ignored; done on the last timer cycle wins
        push(4'h3, 16'h0777, 12'h0FF);
        run_cmd(0, 2, 1'b1);
        push(4'h1, 16'h0042, 12'd1);
        run_cmd(0, TIMEOUT - 1, 1'b0);
        check("done_beats_timeout", err_timeout, 0);

        // timeout, then the next instruction is still accepted
        push(4'h3, 16'h0500, 12'd64);
        run_cmd(0, -1, 1'b0);
        push(4'h4, 16'h0600, 12'd2);
        run_cmd(0, 1, 1'b0);
        check("timeout_sticky", err_timeout, 1);

        // HALT blocks a following COMPUTE until reset
        push(4'hF, 16'h0000, 12'd0);
        instr_in = mk(4'h3, 16'h0900, 12'd9);
        instr_valid = 1'b1;
        tick();
        check("halted_entry", {halted, busy, instr_ready, cmd_valid}, 4'b1000);
        vc_mark = valid_cycles;
        repeat (6) tick();
        check("halt_sticky", {halted, instr_ready, cmd_valid}, 3'b100);
        check("halt_no_issue", valid_cycles - vc_mark, 0);
        do_reset(2);

        // reset while waiting for done drops the command
        push(4'h1, 16'h0040, 12'd2);
        run_cmd(0, -2, 1'b0);
        check("wait_done_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        check("reset_drops_cmd", {retired_cnt, busy, instr_ready}, {16'd0, 1'b0, 1'b1});

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
